// File: rtl/data_mem_bridge_if.sv
// External data-memory bus: one registered request channel from the bridge and
// an acknowledge/read-data return channel from the memory.
interface data_mem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Load/store port to multi-cycle memory bus bridge: posted stores in a circular
// write buffer, store-to-load forwarding, blocking bus reads on load misses.
module data_mem_bridge #(
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      stall,
  data_mem_bridge_if.master         bus,
  output logic [$clog2(WB_DEPTH):0] wb_count
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StLdone} state_e;

  state_e      state_q, state_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic [29:0] wb_addr_q [WB_DEPTH];
  logic [29:0] wb_addr_d [WB_DEPTH];
  logic [31:0] wb_data_q [WB_DEPTH];
  logic [31:0] wb_data_d [WB_DEPTH];

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_q, load_d;

  logic        is_store, is_load, full, hit, load_miss, enq, pop;
  logic [31:0] hit_data;

  // Word accesses only: byte offset is deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign is_store  = mem_write;
  assign is_load   = mem_read & ~mem_write;
  assign full      = (count_q == cnt_t'(WB_DEPTH));
  assign load_miss = is_load & ~hit;
  assign enq       = is_store & ~full & (state_q != StRead);
  assign pop       = (state_q == StWrite) & bus.bus_ack;

  // Walk oldest to newest so the newest matching entry wins; the head entry
  // stays visible while its bus write is still outstanding.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if ((cnt_t'(i) < count_q) && (wb_addr_q[head_q + ptr_t'(i)] == addr[31:2])) begin
        hit      = 1'b1;
        hit_data = wb_data_q[head_q + ptr_t'(i)];
      end
    end
  end

  // Buffer bookkeeping; pop frees a slot only for the following cycle.
  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (enq) begin
      wb_addr_d[tail_q] = addr[31:2];
      wb_data_d[tail_q] = wdata;
    end
    head_d  = head_q + ptr_t'(pop);
    tail_d  = tail_q + ptr_t'(enq);
    count_d = count_q + cnt_t'(enq) - cnt_t'(pop);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_miss) begin
          state_d = StRead;
        end else if (count_d != '0) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (bus.bus_ack) begin
          if (load_miss) begin
            state_d = StRead;
          end else if (count_d != '0) begin
            state_d = StWrite;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        if (bus.bus_ack) begin
          state_d = StLdone;
        end
      end
      StLdone: begin
        state_d = (count_d != '0) ? StWrite : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered bus request: loaded on entry to a transaction, held until ack.
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    load_d      = load_q;
    if ((state_q == StRead) && bus.bus_ack) begin
      load_d = bus.bus_rdata;
    end
    unique case (state_d)
      StRead: begin
        if (state_q != StRead) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wdata_d = '0;
        end
      end
      StWrite: begin
        if ((state_q != StWrite) || pop) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = {wb_addr_d[head_d], 2'b00};
          bus_wdata_d = wb_data_d[head_d];
        end
      end
      default: begin
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
      end
    endcase
  end

  // Processor-facing outputs
  always_comb begin
    stall = 1'b0;
    rdata = '0;
    unique case (state_q)
      StRead:  stall = 1'b1;
      StLdone: rdata = load_q;
      default: begin
        stall = is_store ? full : load_miss;
        if (is_load && hit) begin
          rdata = hit_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      load_q      <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      load_q      <= load_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign wb_count      = count_q;

endmodule
